// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: shares one native register bus between up to four
// requesters. A winner is picked round-robin in IDLE, its command is
// registered, one strobe cycle is issued in ACCESS, and a one-cycle ack
// carrying the read data is returned in ACK.
//
// Optional build macro: REG_BUS_ARB_LOCK_EN
//   When defined, a requester that holds req_lock during its ack cycle
//   keeps the grant for its next access, provided its req_valid is high in
//   the following IDLE cycle. When undefined, req_lock is ignored and
//   arbitration is pure round-robin.
//
// Handshake: a requester raises req_valid with a stable command and holds
// both until it sees its req_ack pulse. At the edge that ends the ack cycle
// it either drops req_valid or presents the next command. Requests are
// sampled only in IDLE, so a valid left high during ACK is never granted twice.
module reg_bus_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                              hclk,
  input  logic                              hresetn,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0]                req_lock,
  input  logic [NUM_REQ-1:0]                req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_be,
  output logic [NUM_REQ-1:0]                req_ack,
  output logic [DATA_WIDTH-1:0]             req_rdata,
  output logic [ADDR_WIDTH-1:0]             reg_addr,
  output logic [DATA_WIDTH-1:0]             reg_wdata,
  output logic [DATA_WIDTH/8-1:0]           reg_be,
  output logic                              reg_we,
  output logic                              reg_re,
  input  logic [DATA_WIDTH-1:0]             reg_rdata,
  output logic                              busy,
  output logic [1:0]                        gnt_id
);

  localparam int BE_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    cmd_we_q, cmd_we_d;
  logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [BE_W-1:0]         cmd_be_q, cmd_be_d;
  logic [1:0]              gnt_id_q, gnt_id_d;
  logic [1:0]              ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic                    rr_found;
  logic [1:0]              rr_winner;
  logic [1:0]              sel_id;

`ifdef REG_BUS_ARB_LOCK_EN
  logic                    lock_q, lock_d;
  logic                    lock_hit;
  logic                    gnt_lock;
`else
  logic                    unused_lock;
  assign unused_lock = ^req_lock;
`endif

  // Round-robin search: first valid requester starting at ptr_q+1, wrapping.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = ptr_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!rr_found && (i == (int'(ptr_q) + k) % NUM_REQ) && req_valid[i]) begin
          rr_found  = 1'b1;
          rr_winner = 2'(i);
        end
      end
    end
  end

`ifdef REG_BUS_ARB_LOCK_EN
  // Locked requester keeps the bus only while it is still requesting.
  always_comb begin
    lock_hit = 1'b0;
    gnt_lock = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id_q == 2'(i)) begin
        lock_hit = lock_q && req_valid[i];
        gnt_lock = req_lock[i];
      end
    end
  end

  assign sel_id = lock_hit ? gnt_id_q : rr_winner;
`else
  assign sel_id = rr_winner;
`endif

  // Next-state logic: capture the winner in IDLE, sample read data in ACCESS,
  // advance the round-robin pointer in ACK.
  always_comb begin
    state_d     = state_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_be_d    = cmd_be_q;
    gnt_id_d    = gnt_id_q;
    ptr_d       = ptr_q;
    rdata_d     = rdata_q;
`ifdef REG_BUS_ARB_LOCK_EN
    lock_d      = lock_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef REG_BUS_ARB_LOCK_EN
        // The lock is spent (or abandoned) by the arbitration in this cycle.
        lock_d = 1'b0;
`endif
        if (|req_valid) begin
          gnt_id_d = sel_id;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_id == 2'(i)) begin
              cmd_we_d    = req_we[i];
              cmd_addr_d  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
              cmd_wdata_d = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
              cmd_be_d    = req_be[i*BE_W +: BE_W];
            end
          end
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!cmd_we_q) begin
          rdata_d = reg_rdata;
        end
        state_d = ST_ACK;
      end
      ST_ACK: begin
        ptr_d   = gnt_id_q;
`ifdef REG_BUS_ARB_LOCK_EN
        lock_d  = gnt_lock;
`endif
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and command registers; reset aborts any access in flight.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= ST_IDLE;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_be_q    <= '0;
      gnt_id_q    <= 2'd0;
      ptr_q       <= 2'(NUM_REQ - 1);
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_be_q    <= cmd_be_d;
      gnt_id_q    <= gnt_id_d;
      ptr_q       <= ptr_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef REG_BUS_ARB_LOCK_EN
  // Lock flag register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end
`endif

  // One-hot ack pulse to the granted requester during ACK.
  always_comb begin
    req_ack = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((state_q == ST_ACK) && (gnt_id_q == 2'(i))) begin
        req_ack[i] = 1'b1;
      end
    end
  end

  assign reg_we    = (state_q == ST_ACCESS) && cmd_we_q;
  assign reg_re    = (state_q == ST_ACCESS) && !cmd_we_q;
  assign reg_be    = (state_q == ST_ACCESS) ? cmd_be_q : '0;
  assign reg_addr  = cmd_addr_q;
  assign reg_wdata = cmd_wdata_q;
  assign req_rdata = rdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Testbench for reg_bus_arbiter with three requesters: table-driven single
// accesses, contention, lock/round-robin ordering, reset mid-access and
// withdrawal of a pending request.
module tb_reg_bus_arbiter;

  localparam int NR = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic              hclk = 1'b0;
  logic              hresetn;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_lock;
  logic [NR-1:0]     req_we;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR*BW-1:0]  req_be;
  logic [NR-1:0]     req_ack;
  logic [DW-1:0]     req_rdata;
  logic [AW-1:0]     reg_addr;
  logic [DW-1:0]     reg_wdata;
  logic [BW-1:0]     reg_be;
  logic              reg_we;
  logic              reg_re;
  logic [DW-1:0]     reg_rdata;
  logic              busy;
  logic [1:0]        gnt_id;

  int checks   = 0;
  int failures = 0;

  // Expected grant order for multi-requester sequences.
  logic [1:0] exp_q[$];

  typedef struct {
    int          id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  reg_bus_arbiter #(
    .NUM_REQ(NR),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .hclk(hclk),
    .hresetn(hresetn),
    .req_valid(req_valid),
    .req_lock(req_lock),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_be(req_be),
    .req_ack(req_ack),
    .req_rdata(req_rdata),
    .reg_addr(reg_addr),
    .reg_wdata(reg_wdata),
    .reg_be(reg_be),
    .reg_we(reg_we),
    .reg_re(reg_re),
    .reg_rdata(reg_rdata),
    .busy(busy),
    .gnt_id(gnt_id)
  );

  // ---------------- clock / reset ----------------
  always #5 hclk = ~hclk;

  // Register file model: fixed pattern derived from the address.
  function automatic logic [31:0] rf_model(input logic [31:0] a);
    if (a == 32'h10) return 32'hCAFE_F00D;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign reg_rdata = rf_model(reg_addr);

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_quiet_bus(input string name);
    chk({name, "_we"},  64'(reg_we),  64'(0));
    chk({name, "_re"},  64'(reg_re),  64'(0));
    chk({name, "_be"},  64'(reg_be),  64'(0));
    chk({name, "_ack"}, 64'(req_ack), 64'(0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_cmd(input int i, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    req_we[i]              = we;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
    req_be[i*BW +: BW]     = be;
  endtask

  // Single access with nobody else requesting; called at a negedge in IDLE.
  task automatic do_single(input vec_t v);
    logic [NR-1:0] ack_exp;
    ack_exp       = '0;
    ack_exp[v.id] = 1'b1;
    chk("single_idle_busy", 64'(busy), 64'(0));
    set_cmd(v.id, v.we, v.addr, v.wdata, v.be);
    req_valid[v.id] = 1'b1;
    @(negedge hclk);  // T+1: ACCESS
    chk("single_acc_we",   64'(reg_we),   64'(v.we));
    chk("single_acc_re",   64'(reg_re),   64'(!v.we));
    chk("single_acc_addr", 64'(reg_addr), 64'(v.addr));
    chk("single_acc_be",   64'(reg_be),   64'(v.be));
    if (v.we) chk("single_acc_wdata", 64'(reg_wdata), 64'(v.wdata));
    chk("single_acc_busy", 64'(busy),     64'(1));
    chk("single_acc_gnt",  64'(gnt_id),   64'(v.id));
    chk("single_acc_ack",  64'(req_ack),  64'(0));
    @(negedge hclk);  // T+2: ACK
    chk("single_ack",      64'(req_ack),  64'(ack_exp));
    if (!v.we) chk("single_rdata", 64'(req_rdata), 64'(v.exp_rdata));
    chk("single_ack_we",   64'(reg_we),   64'(0));
    chk("single_ack_re",   64'(reg_re),   64'(0));
    chk("single_ack_be",   64'(reg_be),   64'(0));
    req_valid[v.id] = 1'b0;
    @(negedge hclk);  // T+3: IDLE
    chk("single_post_busy", 64'(busy), 64'(0));
    chk_quiet_bus("single_post");
  endtask

  // Multi-requester run: requester i performs cnt_i accesses, reissuing right
  // after each ack. If lead >= 0 that requester starts one cycle earlier.
  // Grant order and 3-cycle ack spacing are checked against exp_q.
  task automatic run_arb(input int c0, input int c1, input int c2, input int lead,
                         input logic [NR-1:0] we_mask, input logic [NR-1:0] lock_mask);
    int cnt[NR];
    int nth[NR];
    int cyc;
    int last_cyc;
    int got;
    logic [1:0]    e;
    logic [NR-1:0] ack_exp;
    cnt = '{c0, c1, c2};
    for (int i = 0; i < NR; i++) begin
      nth[i] = 0;
      set_cmd(i, we_mask[i], 32'h100 + 32'(i) * 32'h40, 32'h5500_0000 + 32'(i), 4'hF);
      req_lock[i] = lock_mask[i];
      if (cnt[i] > 0 && (lead < 0 || lead == i)) req_valid[i] = 1'b1;
    end
    if (lead >= 0) begin
      @(negedge hclk);
      for (int i = 0; i < NR; i++) if (cnt[i] > 0 && i != lead) req_valid[i] = 1'b1;
    end
    cyc      = 0;
    last_cyc = -1;
    while (exp_q.size() > 0 && cyc < 60) begin
      @(negedge hclk);
      cyc++;
      if (req_ack != '0) begin
        got = -1;
        for (int i = 0; i < NR; i++) if (req_ack[i] && got < 0) got = i;
        e          = exp_q.pop_front();
        ack_exp    = '0;
        ack_exp[e] = 1'b1;
        chk("arb_grant_order", 64'(req_ack), 64'(ack_exp));
        if (last_cyc >= 0) chk("arb_ack_spacing", 64'(cyc - last_cyc), 64'(3));
        last_cyc = cyc;
        cnt[got]--;
        nth[got]++;
        if (cnt[got] <= 0) begin
          req_valid[got] = 1'b0;
        end else begin
          set_cmd(got, we_mask[got], 32'h100 + 32'(got) * 32'h40 + 32'(nth[got]) * 32'h4,
                  32'h5500_0000 + 32'(got) + 32'(nth[got]) * 32'h100, 4'hF);
        end
      end
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL arb_timeout: got %0d acks missing expected 0", exp_q.size());
      exp_q.delete();
    end
    req_valid = '0;
    req_lock  = '0;
    @(negedge hclk);  // back in IDLE
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{id: 0, we: 1'b0, addr: 32'h0000_0010, wdata: 32'h0,         be: 4'b1111, exp_rdata: 32'hCAFE_F00D};
    vecs[1] = '{id: 1, we: 1'b1, addr: 32'h0000_0004, wdata: 32'h00AB_0000, be: 4'b0100, exp_rdata: 32'h0};
    vecs[2] = '{id: 2, we: 1'b0, addr: 32'h0000_0020, wdata: 32'h0,         be: 4'b0011, exp_rdata: 32'h0020_FFDF};
    vecs[3] = '{id: 0, we: 1'b1, addr: 32'hFFFF_FFFC, wdata: 32'h1234_5678, be: 4'b1111, exp_rdata: 32'h0};
    vecs[4] = '{id: 1, we: 1'b0, addr: 32'h0000_0008, wdata: 32'h0,         be: 4'b1000, exp_rdata: 32'h0008_FFF7};

    hresetn   = 1'b0;
    req_valid = '0;
    req_lock  = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    repeat (2) @(negedge hclk);
    chk("rst_ack",   64'(req_ack),   64'(0));
    chk("rst_rdata", 64'(req_rdata), 64'(0));
    chk("rst_we",    64'(reg_we),    64'(0));
    chk("rst_re",    64'(reg_re),    64'(0));
    chk("rst_be",    64'(reg_be),    64'(0));
    chk("rst_addr",  64'(reg_addr),  64'(0));
    chk("rst_wdata", 64'(reg_wdata), 64'(0));
    chk("rst_busy",  64'(busy),      64'(0));
    chk("rst_gnt",   64'(gnt_id),    64'(0));
    hresetn = 1'b1;
    @(negedge hclk);

    // Table-driven single accesses.
    for (int n = 0; n < 5; n++) do_single(vecs[n]);

    // Contention between 0 and 1, two accesses each: pointer is at 1.
    exp_q = '{2'd0, 2'd1, 2'd0, 2'd1};
    run_arb(2, 2, 0, -1, 3'b000, 3'b000);

    // Requester 1 leads with lock and three writes, requester 0 pending.
`ifdef REG_BUS_ARB_LOCK_EN
    exp_q = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
`else
    exp_q = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
`endif
    run_arb(2, 3, 0, 1, 3'b010, 3'b010);

    // Reset in the middle of requester 2's read access.
    set_cmd(2, 1'b0, 32'h0000_0020, 32'h0, 4'b0110);
    req_valid[2] = 1'b1;
    @(negedge hclk);
    chk("rstmid_pre_re",  64'(reg_re), 64'(1));
    chk("rstmid_pre_gnt", 64'(gnt_id), 64'(2));
    hresetn = 1'b0;
    #1;
    chk("rstmid_ack",   64'(req_ack),   64'(0));
    chk("rstmid_rdata", 64'(req_rdata), 64'(0));
    chk("rstmid_we",    64'(reg_we),    64'(0));
    chk("rstmid_re",    64'(reg_re),    64'(0));
    chk("rstmid_be",    64'(reg_be),    64'(0));
    chk("rstmid_addr",  64'(reg_addr),  64'(0));
    chk("rstmid_busy",  64'(busy),      64'(0));
    chk("rstmid_gnt",   64'(gnt_id),    64'(0));
    req_valid = '0;
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge hclk);
      chk_quiet_bus("rstmid_after");
    end

    // First post-reset tie among all three goes to requester 0.
    exp_q = '{2'd0, 2'd1, 2'd2};
    run_arb(1, 1, 1, -1, 3'b000, 3'b000);

    // Withdrawal: requester 2 drops its request while 0 is being served.
    set_cmd(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
    set_cmd(2, 1'b1, 32'h0000_0040, 32'hDEAD_0002, 4'hF);
    req_valid[0] = 1'b1;
    req_valid[2] = 1'b1;
    @(negedge hclk);
    chk("wd_acc_gnt", 64'(gnt_id), 64'(0));
    chk("wd_acc_re",  64'(reg_re), 64'(1));
    req_valid[2] = 1'b0;
    @(negedge hclk);
    chk("wd_ack",   64'(req_ack),   64'(3'b001));
    chk("wd_rdata", 64'(req_rdata), 64'(32'hCAFE_F00D));
    req_valid[0] = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge hclk);
      chk("wd_idle_busy", 64'(busy), 64'(0));
      chk_quiet_bus("wd_idle");
    end
    do_single(vecs[4]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/reg_bus_arbiter.md
# reg_bus_arbiter

Shares a single native register bus (addr/wdata/be/we/re with combinational rdata) between up to four requesters, e.g. the AHB-Lite slave adapter port and a debug or DMA port. Each requester issues one access at a time with a valid/ack handshake. The arbiter selects a winner round-robin, registers its command, and drives exactly one register-bus strobe cycle. It then returns read data with a one-cycle ack pulse. It sits between the requester-side adapters and the peripheral register file.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters, legal range 2..4.
- ADDR_WIDTH, 32: register address width.
- DATA_WIDTH, 32: data width, a multiple of 8.

Ports:
- hclk  in  1  clock.
- hresetn  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester access request; must be held until ack.
- req_lock  in  NUM_REQ  keep the grant for the next access (see Configuration).
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flat-packed addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flat-packed write data.
- req_be  in  NUM_REQ*(DATA_WIDTH/8)  flat-packed byte enables.
- req_ack  out  NUM_REQ  one-hot single-cycle completion pulse.
- req_rdata  out  DATA_WIDTH  read data; valid only while req_ack is high.
- reg_addr  out  ADDR_WIDTH  register bus address.
- reg_wdata  out  DATA_WIDTH  register bus write data.
- reg_be  out  DATA_WIDTH/8  register bus byte enables.
- reg_we  out  1  write strobe.
- reg_re  out  1  read strobe.
- reg_rdata  in  DATA_WIDTH  combinational read data from the register file.
- busy  out  1  high in the ACCESS and ACK states.
- gnt_id  out  2  index of the current or last granted requester.

## Operation
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - If any req_valid bit is high, select a winner.
  - Register the winner's we/addr/wdata/be and its index, then go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - reg_we = cmd_we; reg_re = !cmd_we. Exactly one of the two is high, for exactly one cycle.
  - reg_addr, reg_wdata and reg_be come from the command register.
  - Capture reg_rdata into req_rdata; for writes, capture is optional.
  - Go to ACK.
- ACK:
  - req_ack[gnt_id] = 1.
  - Update the round-robin pointer to gnt_id.
  - Go to IDLE. req_valid is not sampled in ACK.
- Round-robin: search starts at pointer+1 and wraps modulo NUM_REQ. The pointer resets to NUM_REQ-1, so requester 0 wins the first tie.
- Request inputs are sampled only in IDLE. Command fields may change once ack has been seen.
- A requester may deassert req_valid before it is granted (withdrawal). The arbiter takes no action.
- Outside ACCESS, reg_we, reg_re and reg_be are 0. reg_addr and reg_wdata hold the command register value.
- Reset values: req_ack=0, req_rdata=0, reg_we=0, reg_re=0, reg_be=0, reg_addr=0, reg_wdata=0, busy=0, gnt_id=0, pointer=NUM_REQ-1, state=IDLE.
- Reset mid-transaction aborts the access. No ack is issued and no strobe appears after reset deasserts. Requesters must reissue the access.

## Timing
- Cycle T: IDLE, req_valid[i] high, i wins.
- Cycle T+1: ACCESS, reg strobe high.
- Cycle T+2: ACK, req_ack[i] high with rdata valid.
- Cycle T+3: IDLE, new arbitration.
- Latency from valid to ack: 2 cycles. Maximum throughput: one access per 3 cycles.
- A requester must drop req_valid, or present a new command, at the edge ending its ack cycle. The arbiter samples nothing in that cycle, so stale valids are never double-granted.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers stay pending and are served in round-robin order. Worst-case wait without lock is (NUM_REQ-1)*3 cycles.

## Configuration
- Macro: REG_BUS_ARB_LOCK_EN.
- Defined:
  - If req_lock[gnt_id] is high in the ACK cycle, a lock flag is set.
  - In the following IDLE, the locked requester wins regardless of round-robin order, provided its req_valid is high.
  - If its req_valid is low in that IDLE cycle, the lock clears and normal arbitration applies in the same cycle.
  - The pointer is still updated on every ack.
- Undefined:
  - req_lock is ignored. The lock flag and its logic are absent.
  - Arbitration is pure round-robin.

## Test plan
- Single read: requester 0 reads addr 0x10 while the register file returns 0xCAFE_F00D. Required: reg_re for 1 cycle at T+1; req_ack[0] and req_rdata=0xCAFE_F00D at T+2.
- Byte write: requester 1 writes addr 0x4, be=4'b0100, wdata=0x00AB_0000. Required: reg_we=1, reg_be=4'b0100 and reg_wdata passed through in ACCESS; req_ack[1] one cycle later.
- Contention: requesters 0 and 1 assert simultaneously and each reissues after its ack. Required: grant order 0,1,0,1; acks 3 cycles apart; no requester is granted twice in a row.
- Lock, with the macro defined: requester 1 asserts req_lock and does 3 back-to-back writes while requester 0 is pending. Required: acks to 1,1,1, then 0. With the macro undefined, acks alternate 1,0,1,0.
- Reset mid-operation: assert hresetn low during ACCESS. Required: all outputs return to their reset values immediately; no ack follows; the first post-reset tie goes to requester 0.
- Withdrawal: requester 2 (NUM_REQ=3) drops req_valid before being granted. Required: no strobe and no ack for it; other requesters are unaffected.
